inv_shift_rows_buf: RTL

AES decryption-path InvShiftRows stage with a small output FIFO and valid/ready handshaking on both sides. It accepts one 128-bit AES state per transfer and applies the inverse ShiftRows permutation on enqueue. It buffers up to DEPTH permuted states and presents them in order to the downstream InvSubBytes stage. It is the decryption counterpart of the encryptor's ShiftRows block and uses the same byte layout.

---
 rtl/inv_shift_rows_buf.sv | 124 ++++++++++++
 1 files changed

// File: rtl/inv_shift_rows_buf.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_buf
//
// InvShiftRows stage for the AES decryption path, followed by a small FIFO
// with valid/ready handshaking on both sides. Each accepted 128-bit state is
// permuted on the way in and held until the downstream InvSubBytes stage
// takes it. States leave in the order they arrived.
//
// Byte layout: byte k sits in bits [8k:8k+7], where bit 0 is the MSB of byte 0.
// Bytes are row-major, so byte 4r+c is row r, column c.
// Permutation: out byte 4r+c = in byte 4r+((c-r) mod 4). Row r is rotated
// right by r bytes.
//
// Parameters:
//   DEPTH      FIFO capacity in states. Must be a power of two and >= 2.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (pointers and count only)
//   flush      synchronous discard of every buffered state
//   in_valid   upstream presents in_data
//   in_ready   a state can be accepted this cycle
//   in_data    incoming AES state
//   out_valid  out_data holds the oldest buffered state
//   out_ready  downstream accepts out_data this cycle
//   out_data   InvShiftRows of the oldest accepted state
//   count      number of buffered states (0..DEPTH)
// -----------------------------------------------------------------------------
module inv_shift_rows_buf #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:127]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:127]           out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // The permutation is pure wiring, so the storage holds states that are
  // already permuted.
  logic [0:127] shifted;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi / 4;
      localparam int COL = gi % 4;
      localparam int SRC = 4 * ROW + ((COL - ROW + 4) % 4);
      assign shifted[8*gi +: 8] = in_data[8*SRC +: 8];
    end
  endgenerate

  // The storage is read asynchronously. This gives first-word fall-through:
  // a state is visible on out_data in the cycle after it is written.
  logic [0:127] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;

  logic push;
  logic pop;

  // in_ready does not look at out_ready. This keeps any combinational
  // ready path out of the block. A full FIFO therefore refuses a push even
  // when a pop happens in the same cycle.
  assign in_ready  = !rst && (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];
  assign count     = count_reg;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      // A flush takes priority over any handshake in the same cycle.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow is the wrap.
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // The data storage has no reset. Stale entries are never visible, because
  // out_valid is driven only by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= shifted;
    end
  end

endmodule
